// File: rtl/bcd_event_counter.sv
// N-digit BCD up/down event counter with clear, clamped parallel load, wrap/saturate and sticky ovf.
// Optional lap snapshot register enabled by defining BCD_EVENT_COUNTER_LAP_EN.

module bcd_digit_step (
  input  logic [3:0] d,
  input  logic       cin,
  input  logic       up,
  output logic [3:0] nxt,
  output logic       cout
);
  always_comb begin
    nxt  = d;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (d >= 4'd9) begin
          nxt  = 4'd0;
          cout = 1'b1;
        end else begin
          nxt = d + 4'd1;
        end
      end else begin
        if (d == 4'd0) begin
          nxt  = 4'd9;
          cout = 1'b1;
        end else begin
          nxt = d - 4'd1;
        end
      end
    end
  end
endmodule

module bcd_event_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int SATURATE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    evt,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
`ifdef BCD_EVENT_COUNTER_LAP_EN
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] lap_val,
`endif
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    tc,
  output logic                    ovf
);
  localparam int W = 4*NUM_DIGITS;
  localparam logic [W-1:0] ALL9 = {NUM_DIGITS{4'h9}};

  logic [W-1:0]        count_q, count_d;
  logic                ovf_q, ovf_d;
  logic [W-1:0]        step_val, load_clamped;
  logic [NUM_DIGITS:0] chain;

  assign chain[0] = 1'b1;

  // Ripple chain: carry/borrow out of the top digit marks a wrap at the limit.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    bcd_digit_step u_step (
      .d    (count_q[4*i +: 4]),
      .cin  (chain[i]),
      .up   (up_dn),
      .nxt  (step_val[4*i +: 4]),
      .cout (chain[i+1])
    );
    assign load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
  end

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_clamped;
    end else if (evt) begin
      ovf_d = ovf_q | chain[NUM_DIGITS];
      if (chain[NUM_DIGITS] && (SATURATE != 0)) count_d = count_q;
      else                                       count_d = step_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef BCD_EVENT_COUNTER_LAP_EN
  logic [W-1:0] lap_val_q, lap_val_d;

  // Snapshot captures the post-edge value so a coincident step/clr/load is included.
  always_comb begin
    lap_val_d = lap_val_q;
    if (lap) lap_val_d = count_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lap_val_q <= '0;
    else        lap_val_q <= lap_val_d;
  end

  assign lap_val = lap_val_q;
`endif

  assign count = count_q;
  assign ovf   = ovf_q;
  assign tc    = up_dn ? (count_q == ALL9) : (count_q == '0);
endmodule

// File: tb/tb_bcd_event_counter.sv
// Scoreboard bench: one wrapping and one saturating counter share stimulus; expectations queued per step.
module tb_bcd_event_counter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0, evt = 1'b0, up_dn = 1'b1, load = 1'b0, lap = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] count0, count1, lap_val0, lap_val1;
  logic        tc0, tc1, ovf0, ovf1;

  always #5 clk = ~clk;

  bcd_event_counter #(.NUM_DIGITS(4), .SATURATE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .evt(evt), .up_dn(up_dn), .load(load),
    .load_val(load_val),
`ifdef BCD_EVENT_COUNTER_LAP_EN
    .lap(lap), .lap_val(lap_val0),
`endif
    .count(count0), .tc(tc0), .ovf(ovf0)
  );

  bcd_event_counter #(.NUM_DIGITS(4), .SATURATE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .evt(evt), .up_dn(up_dn), .load(load),
    .load_val(load_val),
`ifdef BCD_EVENT_COUNTER_LAP_EN
    .lap(lap), .lap_val(lap_val1),
`endif
    .count(count1), .tc(tc1), .ovf(ovf1)
  );

`ifndef BCD_EVENT_COUNTER_LAP_EN
  assign lap_val0 = '0;
  assign lap_val1 = '0;
`endif

  typedef struct {
    string       nm;
    logic [15:0] c0, c1, l0, l1;
    logic        o0, o1, t0, t1;
  } exp_t;

  exp_t        sb[$];
  event        chk_ev;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_lap0 = '0, exp_lap1 = '0;

  task automatic push(input string nm, input logic [15:0] e0, input logic o0,
                      input logic [15:0] e1, input logic o1);
    exp_t e;
    e.nm = nm;
    e.c0 = e0; e.o0 = o0; e.t0 = up_dn ? (e0 == 16'h9999) : (e0 == 16'h0000);
    e.c1 = e1; e.o1 = o1; e.t1 = up_dn ? (e1 == 16'h9999) : (e1 == 16'h0000);
    e.l0 = exp_lap0; e.l1 = exp_lap1;
    sb.push_back(e);
  endtask

  task automatic step(input string nm, input logic c, input logic l, input logic [15:0] lv,
                      input logic e, input logic u, input logic lp,
                      input logic [15:0] e0, input logic o0, input logic [15:0] e1, input logic o1);
    clr = c; load = l; load_val = lv; evt = e; up_dn = u; lap = lp;
    @(posedge clk); #1;
    clr = 1'b0; load = 1'b0; evt = 1'b0; lap = 1'b0;
    if (lp) begin
      exp_lap0 = e0;
      exp_lap1 = e1;
    end
    push(nm, e0, o0, e1, o1);
    @(negedge clk); #1;
  endtask

  // Reset asserted mid-cycle; the check fires before any clock edge can occur.
  task automatic arst(input string nm);
    rst_n = 1'b0;
    #1;
    exp_lap0 = '0;
    exp_lap1 = '0;
    push(nm, 16'h0000, 1'b0, 16'h0000, 1'b0);
    -> chk_ev;
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({count0, ovf0, tc0} !== {e.c0, e.o0, e.t0}) begin
          errors++;
          $display("FAIL %s wrap: got count=%h ovf=%b tc=%b, expected count=%h ovf=%b tc=%b",
                   e.nm, count0, ovf0, tc0, e.c0, e.o0, e.t0);
        end
        checks++;
        if ({count1, ovf1, tc1} !== {e.c1, e.o1, e.t1}) begin
          errors++;
          $display("FAIL %s sat: got count=%h ovf=%b tc=%b, expected count=%h ovf=%b tc=%b",
                   e.nm, count1, ovf1, tc1, e.c1, e.o1, e.t1);
        end
`ifdef BCD_EVENT_COUNTER_LAP_EN
        checks++;
        if ({lap_val0, lap_val1} !== {e.l0, e.l1}) begin
          errors++;
          $display("FAIL %s lap: got %h/%h, expected %h/%h", e.nm, lap_val0, lap_val1, e.l0, e.l1);
        end
`endif
      end
    end
  end

  initial begin : stim
    @(negedge clk); #1;
    push("reset_state", 16'h0000, 1'b0, 16'h0000, 1'b0);
    -> chk_ev;
    @(negedge clk); #1;
    rst_n = 1'b1;
    //          name         clr  load lv        evt  up   lap  wrap            sat
    step("hold",         0, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000, 0);
    step("load0123",     0, 1, 16'h0123, 0, 1, 0, 16'h0123, 0, 16'h0123, 0);
    arst("arst_0123");
    step("load0998",     0, 1, 16'h0998, 0, 1, 0, 16'h0998, 0, 16'h0998, 0);
    step("up0999",       0, 0, 16'h0000, 1, 1, 0, 16'h0999, 0, 16'h0999, 0);
    step("up1000",       0, 0, 16'h0000, 1, 1, 0, 16'h1000, 0, 16'h1000, 0);
    step("up1001",       0, 0, 16'h0000, 1, 1, 0, 16'h1001, 0, 16'h1001, 0);
    step("load9998",     0, 1, 16'h9998, 0, 1, 0, 16'h9998, 0, 16'h9998, 0);
    step("up9999",       0, 0, 16'h0000, 1, 1, 0, 16'h9999, 0, 16'h9999, 0);
    step("up_limit",     0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 16'h9999, 1);
    step("up_after",     0, 0, 16'h0000, 1, 1, 0, 16'h0001, 1, 16'h9999, 1);
    step("ovf_sticky",   0, 0, 16'h0000, 0, 1, 0, 16'h0001, 1, 16'h9999, 1);
    step("clr",          1, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000, 0);
    step("load0001",     0, 1, 16'h0001, 0, 0, 0, 16'h0001, 0, 16'h0001, 0);
    step("dn0000",       0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 16'h0000, 0);
    step("dn_limit",     0, 0, 16'h0000, 1, 0, 0, 16'h9999, 1, 16'h0000, 1);
    step("dn_after",     0, 0, 16'h0000, 1, 0, 0, 16'h9998, 1, 16'h0000, 1);
    step("clr_load_evt", 1, 1, 16'h4321, 1, 1, 0, 16'h0000, 0, 16'h0000, 0);
    step("load_clamp",   0, 1, 16'hF3A2, 1, 1, 0, 16'h9392, 0, 16'h9392, 0);
    step("up9393",       0, 0, 16'h0000, 1, 1, 0, 16'h9393, 0, 16'h9393, 0);
    step("load9999",     0, 1, 16'h9999, 0, 1, 0, 16'h9999, 0, 16'h9999, 0);
    step("load_no_ovf",  0, 1, 16'hFFFF, 0, 1, 0, 16'h9999, 0, 16'h9999, 0);
    step("up_wrap2",     0, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 16'h9999, 1);
    arst("arst_ovf");
    step("up_post_rst",  0, 0, 16'h0000, 1, 1, 0, 16'h0001, 0, 16'h0001, 0);
    step("load0456",     0, 1, 16'h0456, 0, 1, 0, 16'h0456, 0, 16'h0456, 0);
    step("evt_lap",      0, 0, 16'h0000, 1, 1, 1, 16'h0457, 0, 16'h0457, 0);
    step("clr_keeps_lap",1, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h0000, 0);
    step("load_lap",     0, 1, 16'h0088, 0, 1, 1, 16'h0088, 0, 16'h0088, 0);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
